// File: rtl/pir_emulator.sv
// PIR motion sensor output emulator: turns a raw trigger into a sensor-style
// pulse with warm-up, hold, optional retrigger and post-hold blocking.
module pir_emulator #(
  parameter int unsigned WARMUP_CYCLES = 100_000_000,
  parameter int unsigned HOLD_CYCLES   = 300_000_000,
  parameter int unsigned BLOCK_CYCLES  = 250_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        retrig,
  output logic        motion_out,
  output logic        ready,
  output logic [1:0]  state,
  output logic [15:0] event_count
);

  localparam int unsigned MaxWh     = (WARMUP_CYCLES > HOLD_CYCLES) ? WARMUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxWh > BLOCK_CYCLES) ? MaxWh : BLOCK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] WarmupLoad = CntW'(WARMUP_CYCLES);
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] BlockLoad  = CntW'(BLOCK_CYCLES);

  typedef enum logic [1:0] {
    StWarmup = 2'd0,
    StIdle   = 2'd1,
    StHold   = 2'd2,
    StBlock  = 2'd3
  } state_e;

  logic trig_s1_q, trig_s2_q, trig_prev_q;
  logic retrig_s1_q, retrig_s2_q;
  logic trig_edge;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     count_q, count_d;
  logic            motion_q, motion_d;
  logic            ready_q, ready_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
      retrig_s1_q <= 1'b0;
      retrig_s2_q <= 1'b0;
    end else begin
      trig_s1_q   <= trigger;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_s2_q;
      retrig_s1_q <= retrig;
      retrig_s2_q <= retrig_s1_q;
    end
  end

  assign trig_edge = trig_s2_q & ~trig_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StWarmup;
      cnt_q    <= WarmupLoad;
      count_q  <= 16'd0;
      motion_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      motion_q <= motion_d;
      ready_q  <= ready_d;
    end
  end

  // Timed states leave on a count of 1; <= also covers a zero warm-up load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    unique case (state_q)
      StWarmup: begin
        if (cnt_q <= CntOne) state_d = StIdle;
        else                 cnt_d   = cnt_q - CntOne;
      end
      StIdle: begin
        if (trig_edge) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
          count_d = count_q + 16'd1;
        end
      end
      StHold: begin
        if (trig_edge && retrig_s2_q) begin
          cnt_d = HoldLoad;
        end else if (cnt_q <= CntOne) begin
          if (BLOCK_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StBlock;
            cnt_d   = BlockLoad;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StBlock: begin
        if (cnt_q <= CntOne) state_d = StIdle;
        else                 cnt_d   = cnt_q - CntOne;
      end
      default: state_d = StWarmup;
    endcase
    motion_d = (state_d == StHold);
    ready_d  = (state_d == StIdle) || (state_d == StHold);
  end

  assign motion_out  = motion_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign event_count = count_q;

endmodule

// File: tb/tb_pir_emulator.sv
// Scoreboard bench for pir_emulator: stimulus pushes expected output changes
// (edge number + output values); monitors pop and compare on every change.
module tb_pir_emulator;

  typedef struct packed {
    int          cyc;
    logic [1:0]  st;
    logic        m;
    logic        r;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0, trigger = 1'b0, retrig = 1'b0;
  logic reset_z = 1'b0, trig_z = 1'b0, retrig_z = 1'b0;

  logic        motion_a, ready_a, motion_z, ready_z;
  logic [1:0]  state_a, state_z;
  logic [15:0] count_a, count_z;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  exp_t q_a[$];
  exp_t q_z[$];

  pir_emulator #(
    .WARMUP_CYCLES(20),
    .HOLD_CYCLES  (10),
    .BLOCK_CYCLES (5)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .retrig     (retrig),
    .motion_out (motion_a),
    .ready      (ready_a),
    .state      (state_a),
    .event_count(count_a)
  );

  pir_emulator #(
    .WARMUP_CYCLES(0),
    .HOLD_CYCLES  (10),
    .BLOCK_CYCLES (0)
  ) u_z (
    .clk        (clk),
    .reset      (reset_z),
    .trigger    (trig_z),
    .retrig     (retrig_z),
    .motion_out (motion_z),
    .ready      (ready_z),
    .state      (state_z),
    .event_count(count_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int sel, input int c, input logic [1:0] st, input logic m,
                      input logic r, input logic [15:0] cnt);
    exp_t e;
    e = '{cyc: c, st: st, m: m, r: r, c: cnt};
    if (sel == 0) q_a.push_back(e);
    else          q_z.push_back(e);
  endtask

  // Wait for the next falling edge whose preceding rising-edge number is k.
  task automatic at(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  task automatic pulse(input int sel, input int k, input int len);
    at(k);
    if (sel == 0) trigger = 1'b1; else trig_z = 1'b1;
    at(k + len);
    if (sel == 0) trigger = 1'b0; else trig_z = 1'b0;
  endtask

  task automatic cmp_rec(input string tag, input exp_t e, input logic [19:0] cur);
    chk({tag, "_edge"},  cyc,        e.cyc);
    chk({tag, "_state"}, cur[19:18], e.st);
    chk({tag, "_motion"}, cur[17],   e.m);
    chk({tag, "_ready"}, cur[16],    e.r);
    chk({tag, "_count"}, cur[15:0],  e.c);
  endtask

  logic [19:0] cur_a, prev_a = '0, cur_z, prev_z = '0;

  always @(negedge clk) begin
    exp_t e;
    cur_a = {state_a, motion_a, ready_a, count_a};
    if (cur_a !== prev_a) begin
      prev_a = cur_a;
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected: outputs changed to %0h with nothing expected (edge %0d)",
                 cur_a, cyc);
      end else begin
        e = q_a.pop_front();
        cmp_rec("a", e, cur_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cur_z = {state_z, motion_z, ready_z, count_z};
    if (cur_z !== prev_z) begin
      prev_z = cur_z;
      if (q_z.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL z_unexpected: outputs changed to %0h with nothing expected (edge %0d)",
                 cur_z, cyc);
      end else begin
        e = q_z.pop_front();
        cmp_rec("z", e, cur_z);
      end
    end
  end

  initial begin
    // Reset values while reset is held.
    at(1);
    chk("rst_motion", motion_a, 0);
    chk("rst_ready",  ready_a,  0);
    chk("rst_state",  state_a,  0);
    chk("rst_count",  count_a,  0);

    // Warm-up: release after edge 2, IDLE after 20 more edges; early trigger ignored.
    push(0, 22, 2'd1, 1'b0, 1'b1, 16'd0);
    at(2);
    reset = 1'b1;
    pulse(0, 5, 3);

    // Single pulse: trigger first sampled at edge 31.
    push(0, 33, 2'd2, 1'b1, 1'b1, 16'd1);
    push(0, 43, 2'd3, 1'b0, 1'b0, 16'd1);
    push(0, 48, 2'd1, 1'b0, 1'b1, 16'd1);
    pulse(0, 30, 3);

    // Retriggerable: reload at edge 64 stretches pulse to 16 cycles.
    at(50);
    retrig = 1'b1;
    push(0, 58, 2'd2, 1'b1, 1'b1, 16'd2);
    push(0, 74, 2'd3, 1'b0, 1'b0, 16'd2);
    push(0, 79, 2'd1, 1'b0, 1'b1, 16'd2);
    pulse(0, 55, 2);
    pulse(0, 61, 2);

    // Single-shot: second edge discarded, pulse stays 10 cycles.
    at(80);
    retrig = 1'b0;
    push(0, 88, 2'd2, 1'b1, 1'b1, 16'd3);
    push(0, 98, 2'd3, 1'b0, 1'b0, 16'd3);
    push(0, 103, 2'd1, 1'b0, 1'b1, 16'd3);
    pulse(0, 85, 2);
    pulse(0, 91, 2);

    // Edges inside BLOCK (edge 119) and on its last cycle (edge 123) are dropped.
    push(0, 108, 2'd2, 1'b1, 1'b1, 16'd4);
    push(0, 118, 2'd3, 1'b0, 1'b0, 16'd4);
    push(0, 123, 2'd1, 1'b0, 1'b1, 16'd4);
    pulse(0, 105, 2);
    pulse(0, 116, 2);
    pulse(0, 120, 2);

    // Edge on first IDLE cycle (edge 149) accepted; retrigger on last HOLD cycle (159).
    push(0, 133, 2'd2, 1'b1, 1'b1, 16'd5);
    push(0, 143, 2'd3, 1'b0, 1'b0, 16'd5);
    push(0, 148, 2'd1, 1'b0, 1'b1, 16'd5);
    push(0, 149, 2'd2, 1'b1, 1'b1, 16'd6);
    push(0, 169, 2'd3, 1'b0, 1'b0, 16'd6);
    push(0, 174, 2'd1, 1'b0, 1'b1, 16'd6);
    pulse(0, 130, 2);
    at(140);
    retrig = 1'b1;
    pulse(0, 146, 2);
    pulse(0, 156, 2);

    // Wrap: preload 0xFFFF, one more pulse gives 0x0000.
    push(0, 181, 2'd1, 1'b0, 1'b1, 16'hFFFF);
    at(180);
    #2 force u_dut.count_q = 16'hFFFF;
    at(182);
    release u_dut.count_q;
    push(0, 188, 2'd2, 1'b1, 1'b1, 16'h0000);
    push(0, 198, 2'd3, 1'b0, 1'b0, 16'h0000);
    push(0, 203, 2'd1, 1'b0, 1'b1, 16'h0000);
    pulse(0, 185, 2);

    // Reset mid-HOLD clears outputs without waiting for a clock edge.
    push(0, 213, 2'd2, 1'b1, 1'b1, 16'd1);
    push(0, 217, 2'd0, 1'b0, 1'b0, 16'd0);
    pulse(0, 210, 2);
    at(216);
    #2 reset = 1'b0;
    #1;
    chk("midhold_motion", motion_a, 0);
    chk("midhold_ready",  ready_a,  0);
    chk("midhold_state",  state_a,  0);
    chk("midhold_count",  count_a,  0);

    // Full warm-up again after release; trigger during it ignored.
    push(0, 240, 2'd1, 1'b0, 1'b1, 16'd0);
    push(0, 245, 2'd2, 1'b1, 1'b1, 16'd1);
    push(0, 255, 2'd3, 1'b0, 1'b0, 16'd1);
    push(0, 260, 2'd1, 1'b0, 1'b1, 16'd1);
    at(220);
    reset = 1'b1;
    pulse(0, 225, 2);
    pulse(0, 242, 2);

    // Zero warm-up / zero block instance: IDLE one edge after release, HOLD->IDLE.
    push(1, 271, 2'd1, 1'b0, 1'b1, 16'd0);
    push(1, 278, 2'd2, 1'b1, 1'b1, 16'd1);
    push(1, 288, 2'd1, 1'b0, 1'b1, 16'd1);
    push(1, 289, 2'd2, 1'b1, 1'b1, 16'd2);
    push(1, 299, 2'd1, 1'b0, 1'b1, 16'd2);
    at(270);
    reset_z = 1'b1;
    pulse(1, 275, 2);
    pulse(1, 286, 2);

    at(310);
    chk("a_queue_empty", q_a.size(), 0);
    chk("z_queue_empty", q_z.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
